// File: rtl/i2s_codec_bridge.sv
// I2S master bridge: serialises one 16-bit L/R pair per audio_en frame and captures one pair back.
// Optional build macro I2S_LOOPBACK_EN feeds the internal serial output back into the RX path.
module i2s_codec_bridge #(
  parameter int BCLK_HALF = 9
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        audio_en,
  input  logic [15:0] audio_lo,
  input  logic [15:0] audio_ro,
  output logic [15:0] audio_li,
  output logic [15:0] audio_ri,
  output logic        rx_valid,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_sdo,
  input  logic        i2s_sdi,
  output logic        busy,
  output logic        overrun
);

  // Handshake: audio_en is a one-cycle strobe accepted only in IDLE; rx_valid is a one-cycle
  // strobe with no back-pressure, audio_li/audio_ri hold until the next strobe.
  typedef enum logic {IDLE, XFER} state_t;

  localparam int CW = 5;
  localparam logic [CW-1:0] HALF_M1   = CW'(BCLK_HALF - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(2 * BCLK_HALF - 1);

  state_t      state, state_nxt;
  logic [CW-1:0] cnt;
  logic [5:0]  slot;
  logic [31:0] tx;
  logic [15:0] rx_l, rx_r;

  logic       slot_end, frame_end, bclk_rise;
  logic [5:0] slot_nxt;
  logic [4:0] j_nxt, bit_idx;
  logic       sdo_nxt, rx_slot, din;

  assign busy      = (state == XFER);
  assign slot_end  = busy && (cnt == SLOT_LAST);
  assign frame_end = slot_end && (slot == 6'd63);
  assign bclk_rise = busy && (cnt == HALF_M1);

  // Next slot's data bit: channel slots 1..16 carry sample bits 15..0, tx = {ro, lo}.
  assign slot_nxt = slot + 6'd1;
  assign j_nxt    = slot_nxt[4:0];
  assign bit_idx  = {slot_nxt[5], 4'(5'd16 - j_nxt)};
  assign sdo_nxt  = (j_nxt != 5'd0) && (j_nxt <= 5'd16) ? tx[bit_idx] : 1'b0;
  assign rx_slot  = (slot[4:0] != 5'd0) && (slot[4:0] <= 5'd16);

`ifdef I2S_LOOPBACK_EN
  logic unused_sdi;
  assign unused_sdi = i2s_sdi;
  assign din        = i2s_sdo;
`else
  assign din        = i2s_sdi;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (audio_en)  state_nxt = XFER;
      XFER:    if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      slot     <= '0;
      tx       <= '0;
      rx_l     <= '0;
      rx_r     <= '0;
      audio_li <= '0;
      audio_ri <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      i2s_bclk <= 1'b0;
      i2s_lrck <= 1'b1;
      i2s_sdo  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == IDLE) begin
        if (audio_en) begin
          tx       <= {audio_ro, audio_lo};
          cnt      <= '0;
          slot     <= '0;
          rx_l     <= '0;
          rx_r     <= '0;
          i2s_bclk <= 1'b0;
          i2s_lrck <= 1'b0;
          i2s_sdo  <= 1'b0;
        end
      end else begin
        if (audio_en) overrun <= 1'b1;
        // Sample on the edge that raises bclk, mid-slot where sdi is stable.
        if (bclk_rise) begin
          i2s_bclk <= 1'b1;
          if (rx_slot) begin
            if (slot[5]) rx_r <= {rx_r[14:0], din};
            else         rx_l <= {rx_l[14:0], din};
          end
        end
        if (slot_end) begin
          cnt      <= '0;
          i2s_bclk <= 1'b0;
          if (frame_end) begin
            slot     <= '0;
            i2s_lrck <= 1'b1;
            i2s_sdo  <= 1'b0;
            audio_li <= rx_l;
            audio_ri <= rx_r;
            rx_valid <= 1'b1;
          end else begin
            slot     <= slot_nxt;
            i2s_lrck <= slot_nxt[5];
            i2s_sdo  <= sdo_nxt;
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_codec_bridge.sv
// Directed bench for i2s_codec_bridge: bench-timed ADC model, scoreboard of captured samples.
module tb_i2s_codec_bridge;

  localparam int H  = 9;
  localparam int FL = 128 * H;
  localparam int SL = 2 * H;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        audio_en = 1'b0;
  logic [15:0] audio_lo = '0, audio_ro = '0;
  logic [15:0] audio_li, audio_ri;
  logic        rx_valid, i2s_bclk, i2s_lrck, i2s_sdo, i2s_sdi, busy, overrun;

  i2s_codec_bridge #(.BCLK_HALF(H)) dut (
    .clk(clk), .rstn(rstn), .audio_en(audio_en), .audio_lo(audio_lo), .audio_ro(audio_ro),
    .audio_li(audio_li), .audio_ri(audio_ri), .rx_valid(rx_valid), .i2s_bclk(i2s_bclk),
    .i2s_lrck(i2s_lrck), .i2s_sdo(i2s_sdo), .i2s_sdi(i2s_sdi), .busy(busy), .overrun(overrun)
  );

  // Clock/reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model timed from the bench's own record of the audio_en cycle.
  int          t_en = -100000;
  logic [15:0] adc_l = '0, adc_r = '0;

  function automatic logic adc_fn(input int d, input logic [15:0] l, input logic [15:0] r);
    int k, j;
    if (d < 1 || d > FL) return 1'b0;
    k = (d - 1) / SL;
    j = k % 32;
    if (j < 1 || j > 16) return 1'b0;
    return (k < 32) ? l[16 - j] : r[16 - j];
  endfunction

  assign i2s_sdi = adc_fn(cyc - t_en, adc_l, adc_r);

  // Scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] last_rx = '0;
  logic        exp_ovr = 1'b0;
  logic [15:0] cur_lo, cur_ro;
  int n_err = 0;
  int n_checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: pulse audio_en for the cycle at the current negedge.
  task automatic start(input logic [15:0] lo, input logic [15:0] ro,
                       input logic [15:0] al, input logic [15:0] ar, input bit push);
    @(negedge clk);
    t_en = cyc;
    audio_en = 1'b1;
    audio_lo = lo;
    audio_ro = ro;
    adc_l = al;
    adc_r = ar;
    cur_lo = lo;
    cur_ro = ro;
    if (push) begin
`ifdef I2S_LOOPBACK_EN
      exp_q.push_back({ro, lo});
`else
      exp_q.push_back({ar, al});
`endif
    end
  endtask

  // Observe cycles T+1..T+len after a start(), optionally firing a stray audio_en at T+ovr_at.
  task automatic watch(input int ovr_at, input int len);
    int busy_n = 0, busy_after = 0, rises = 0, lr_rise = -1;
    int bclk_bad = 0, lrck_bad = 0, sdo_moves = 0, rxv_n = 0, rxv_at = -1;
    logic [63:0] sdo_vec = '0;
    logic prev_bclk = 1'b0, prev_lrck = 1'b1, prev_sdo = 1'b0;
    logic [31:0] got;
    for (int d = 1; d <= len; d++) begin
      @(negedge clk);
      audio_en = (d == ovr_at);
      if (d == ovr_at) exp_ovr = 1'b1;
      if (d <= FL) begin
        busy_n += int'(busy);
        if (i2s_bclk !== (((d - 1) % SL) >= H)) bclk_bad++;
        if (i2s_lrck !== (((d - 1) / SL) >= 32)) lrck_bad++;
        if (((d - 1) % SL) == H) sdo_vec[63 - (d - 1) / SL] = i2s_sdo;
        if (((d - 1) % SL) != 0 && i2s_sdo !== prev_sdo) sdo_moves++;
      end else begin
        busy_after += int'(busy);
      end
      if (i2s_bclk && !prev_bclk) rises++;
      if (i2s_lrck && !prev_lrck && lr_rise < 0) lr_rise = d;
      if (rx_valid) begin
        rxv_n++;
        rxv_at = d;
        if (exp_q.size() == 0) begin
          chk("rx_unexpected", 64'(rxv_n), 64'd0);
        end else begin
          last_rx = exp_q.pop_front();
          got = {audio_ri, audio_li};
          chk("rx_data", 64'(got), 64'(last_rx));
        end
      end
      prev_bclk = i2s_bclk;
      prev_lrck = i2s_lrck;
      prev_sdo  = i2s_sdo;
    end
    chk("busy_cycles", 64'(busy_n), 64'(FL));
    chk("busy_after", 64'(busy_after), 64'd0);
    chk("bclk_rises", 64'(rises), 64'd64);
    chk("bclk_shape", 64'(bclk_bad), 64'd0);
    chk("lrck_shape", 64'(lrck_bad), 64'd0);
    chk("lrck_rise", 64'(lr_rise), 64'(1 + 32 * SL));
    chk("sdo_frame", sdo_vec, {1'b0, cur_lo, 15'b0, 1'b0, cur_ro, 15'b0});
    chk("sdo_midslot", 64'(sdo_moves), 64'd0);
    chk("rxv_count", 64'(rxv_n), 64'd1);
    chk("rxv_cycle", 64'(rxv_at), 64'(FL + 1));
    chk("rx_hold", 64'({audio_ri, audio_li}), 64'(last_rx));
    chk("overrun", 64'(overrun), 64'(exp_ovr));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rxv"}, 64'(rx_valid), 64'd0);
    chk({tag, "_ovr"}, 64'(overrun), 64'd0);
    chk({tag, "_bclk"}, 64'(i2s_bclk), 64'd0);
    chk({tag, "_lrck"}, 64'(i2s_lrck), 64'd1);
    chk({tag, "_sdo"}, 64'(i2s_sdo), 64'd0);
    chk({tag, "_li"}, 64'(audio_li), 64'd0);
    chk({tag, "_ri"}, 64'(audio_ri), 64'd0);
  endtask

  task automatic idle_run(input string tag, input int len);
    int rxv_n = 0, busy_n = 0, bclk_n = 0, lrck_bad = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      rxv_n += int'(rx_valid);
      busy_n += int'(busy);
      bclk_n += int'(i2s_bclk);
      if (i2s_lrck !== 1'b1) lrck_bad++;
    end
    chk({tag, "_rxv"}, 64'(rxv_n), 64'd0);
    chk({tag, "_busy"}, 64'(busy_n), 64'd0);
    chk({tag, "_bclk"}, 64'(bclk_n), 64'd0);
    chk({tag, "_lrck"}, 64'(lrck_bad), 64'd0);
  endtask

  initial begin
    logic [15:0] r0, r1, r2, r3;

    // Reset held: reset values
    repeat (4) @(negedge clk);
    chk_reset_vals("rst_hold");
    rstn = 1'b1;

    // Long idle after release
    idle_run("idle", 2000);
    chk("idle_li", 64'(audio_li), 64'd0);
    chk("idle_ri", 64'(audio_ri), 64'd0);

    // Reference frame with asymmetric data and an all-ones/LSB-only ADC
    start(16'h8001, 16'h7FFE, 16'hFFFF, 16'h0001, 1'b1);
    watch(0, 1249);

    // Fixed pattern, then random samples, at a 1250-cycle cadence
    start(16'h1234, 16'hABCD, 16'h5A5A, 16'hC3C3, 1'b1);
    watch(0, 1249);
    r0 = 16'($urandom_range(0, 65535));
    r1 = 16'($urandom_range(0, 65535));
    r2 = 16'($urandom_range(0, 65535));
    r3 = 16'($urandom_range(0, 65535));
    start(r0, r1, r2, r3, 1'b1);
    watch(0, 1249);

    // Stray audio_en mid-frame: overrun, frame intact, no second frame
    start(16'h0F0F, 16'hF0F0, 16'h8000, 16'h7FFF, 1'b1);
    watch(600, 1249);
    idle_run("post_ovr", 100);
    chk("ovr_sticky", 64'(overrun), 64'd1);

    // Reset mid-frame aborts without rx_valid
    start(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0);
    repeat (399) @(negedge clk);
    audio_en = 1'b0;
    rstn = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    exp_ovr = 1'b0;
    last_rx = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    idle_run("post_rst", 1300);

    // audio_en on the final frame cycle counts as arriving in XFER
    start(16'hCAFE, 16'hBEEF, 16'h0001, 16'hFFFF, 1'b1);
    watch(FL, 1249);

    // Clean frame afterwards; overrun stays set
    start(16'h1234, 16'hABCD, 16'hFFFF, 16'h0001, 1'b1);
    watch(0, 1249);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
